// File: rtl/render_pkg.sv
// Shared types and constants for the render scheduler and its VGA-side pixel mux.
package render_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        START,
        WAIT,
        NEXT,
        FINISH
    } sched_state_t;

    localparam int PIX_X_W   = 8;
    localparam int PIX_Y_W   = 8;
    localparam int PIX_RGB_W = 24;
    localparam int WD_CNT_W  = 16;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_port_mux.sv
// Selects one client's pixel stream by index and registers it onto the VGA write port.
module pixel_port_mux
    import render_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int IDX_W       = 2
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             capture,
    input  logic                             kill,
    input  logic [IDX_W-1:0]                 idx,
    input  logic [NUM_CLIENTS-1:0]           client_plot,
    input  logic [PIX_X_W*NUM_CLIENTS-1:0]   client_x,
    input  logic [PIX_Y_W*NUM_CLIENTS-1:0]   client_y,
    input  logic [PIX_RGB_W*NUM_CLIENTS-1:0] client_rgb,
    output logic [PIX_X_W-1:0]               vga_x,
    output logic [PIX_Y_W-1:0]               vga_y,
    output logic [PIX_RGB_W-1:0]             vga_rgb,
    output logic                             vga_plot
);

    logic [PIX_X_W-1:0]   sel_x;
    logic [PIX_Y_W-1:0]   sel_y;
    logic [PIX_RGB_W-1:0] sel_rgb;
    logic                 sel_plot;

    always_comb begin
        sel_x    = '0;
        sel_y    = '0;
        sel_rgb  = '0;
        sel_plot = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (int'(idx) == i) begin
                sel_x    = client_x[i*PIX_X_W +: PIX_X_W];
                sel_y    = client_y[i*PIX_Y_W +: PIX_Y_W];
                sel_rgb  = client_rgb[i*PIX_RGB_W +: PIX_RGB_W];
                sel_plot = client_plot[i];
            end
        end
    end

    // Coordinates and colour hold their last value outside capture; only plot drops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vga_x    <= '0;
            vga_y    <= '0;
            vga_rgb  <= '0;
            vga_plot <= 1'b0;
        end else if (capture) begin
            vga_x    <= sel_x;
            vga_y    <= sel_y;
            vga_rgb  <= sel_rgb;
            vga_plot <= sel_plot & ~kill;
        end else begin
            vga_plot <= 1'b0;
        end
    end

endmodule

// File: rtl/render_scheduler.sv
// Per-frame drawer sequencer owning the single VGA write port.
// Watchdog on hung clients is built only with RENDER_SCHED_WATCHDOG_EN defined.
//
// state  | meaning
// IDLE   | waiting for frame_start
// SELECT | scan latched mask at idx for the next enabled client
// START  | one-cycle draw pulse to client idx
// WAIT   | forward client idx pixels until its done
// NEXT   | advance idx or finish
// FINISH | one-cycle frame_done pulse
module render_scheduler
    import render_pkg::*;
#(
    parameter int NUM_CLIENTS     = 4,
    parameter int WATCHDOG_CYCLES = 65535
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             frame_start,
    input  logic [NUM_CLIENTS-1:0]           client_en,
    output logic [NUM_CLIENTS-1:0]           client_draw,
    input  logic [NUM_CLIENTS-1:0]           client_done,
    input  logic [NUM_CLIENTS-1:0]           client_plot,
    input  logic [PIX_X_W*NUM_CLIENTS-1:0]   client_x,
    input  logic [PIX_Y_W*NUM_CLIENTS-1:0]   client_y,
    input  logic [PIX_RGB_W*NUM_CLIENTS-1:0] client_rgb,
    output logic [PIX_X_W-1:0]               vga_x,
    output logic [PIX_Y_W-1:0]               vga_y,
    output logic [PIX_RGB_W-1:0]             vga_rgb,
    output logic                             vga_plot,
    output logic                             busy,
    output logic                             frame_done,
    output logic                             frame_overrun,
    output logic                             timeout_err
);

    localparam int IDX_W = idx_width(NUM_CLIENTS);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NUM_CLIENTS - 1);
    localparam logic [WD_CNT_W-1:0] WD_LIMIT = WD_CNT_W'(WATCHDOG_CYCLES - 1);

    sched_state_t           state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_CLIENTS-1:0] mask_q;
    logic                   accept;
    logic                   capture;
    logic                   plot_kill;
    logic                   wd_hit;
    logic                   done_sel;

    assign accept   = (state_q == IDLE) && frame_start;
    assign done_sel = client_done[idx_q];
    assign busy     = (state_q != IDLE);

`ifdef RENDER_SCHED_WATCHDOG_EN
    logic [WD_CNT_W-1:0] wd_cnt_q;

    // Held at zero outside WAIT so every WAIT visit starts counting from zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_cnt_q <= '0;
        end else if (state_q != WAIT) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
        end
    end

    assign wd_hit = (state_q == WAIT) && (wd_cnt_q == WD_LIMIT) && !done_sel;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timeout_err <= 1'b0;
        end else if (accept) begin
            timeout_err <= 1'b0;
        end else if (wd_hit) begin
            timeout_err <= 1'b1;
        end
    end
`else
    logic wd_limit_unused;
    assign wd_limit_unused = ^WD_LIMIT;
    assign wd_hit          = 1'b0;
    assign timeout_err     = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        capture   = 1'b0;
        plot_kill = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    idx_d   = '0;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (mask_q[idx_q]) begin
                    state_d = START;
                end else if (idx_q == IDX_LAST) begin
                    state_d = FINISH;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                capture = 1'b1;
                if (done_sel) begin
                    state_d = NEXT;
                end else if (wd_hit) begin
                    plot_kill = 1'b1;
                    state_d   = NEXT;
                end
            end
            NEXT: begin
                if (idx_q == IDX_LAST) begin
                    state_d = FINISH;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = SELECT;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (accept) begin
                mask_q <= client_en;
            end
        end
    end

    // Pulse outputs are loaded from the next state so they line up with START/FINISH.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            client_draw   <= '0;
            frame_done    <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            client_draw   <= (state_d == START) ? (NUM_CLIENTS'(1) << idx_d) : '0;
            frame_done    <= (state_d == FINISH);
            frame_overrun <= frame_start && busy;
        end
    end

    pixel_port_mux #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .IDX_W       (IDX_W)
    ) u_pixel_port_mux (
        .clk         (clk),
        .resetn      (resetn),
        .capture     (capture),
        .kill        (plot_kill),
        .idx         (idx_q),
        .client_plot (client_plot),
        .client_x    (client_x),
        .client_y    (client_y),
        .client_rgb  (client_rgb),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_rgb     (vga_rgb),
        .vga_plot    (vga_plot)
    );

endmodule
